pds_if: RTL and testbench

- Ingress port block of the packet switch; one instance per switch port (instance for port 0 configured with PORTNO=0).
- Accepts a byte-serial packet stream from the port driver and decodes the destination byte into a one-hot or multicast port mask.
- Rejects illegal destinations; checks the length byte against the actual packet length.
- Buffers accepted bytes in a small FIFO and presents them, tagged with mask and error flag, to the switch fabric.

---
 rtl/pds_pkg.sv | 47 ++++
 rtl/pds_fifo.sv | 57 +++++
 rtl/pds_if.sv | 175 +++++++++++++++++
 tb/tb_pds_if.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pds_pkg.sv
// pds_pkg: shared types and helpers for the packet-switch ingress block.
//   MCAST_BIT    - destination byte bit that selects multicast addressing
//   MAX_PORTS    - widest switch supported; decoded masks use this width
//   state_t      - ingress parser states
//   dest_dec_t   - decoded destination: legal flag plus MAX_PORTS-wide mask
//   dest_to_mask - destination byte -> port mask for a switch of nports ports
package pds_pkg;

  localparam int unsigned MCAST_BIT = 7;
  localparam int unsigned MAX_PORTS = 8;

  typedef enum logic [1:0] {
    IDLE,
    LEN,
    PAY,
    DROP
  } state_t;

  typedef struct packed {
    logic                 legal;
    logic [MAX_PORTS-1:0] mask;
  } dest_dec_t;

  // Single: one-hot on dest[2:0]; upper address bits must be zero and the
  // port must exist. Multicast: low bits are the mask, clipped to the ports
  // that exist; an empty mask is illegal.
  function automatic dest_dec_t dest_to_mask(input logic [7:0] dest,
                                             input int unsigned nports);
    dest_dec_t            r;
    logic [MAX_PORTS-1:0] port_lim;
    port_lim = '0;
    for (int unsigned i = 0; i < MAX_PORTS; i++) begin
      if (i < nports) port_lim[i] = 1'b1;
    end
    r.mask  = '0;
    r.legal = 1'b0;
    if (dest[MCAST_BIT]) begin
      r.mask  = dest[MAX_PORTS-1:0] & port_lim;
      r.legal = |r.mask;
    end else begin
      r.mask[dest[2:0]] = 1'b1;
      r.legal = (dest[6:3] == 4'd0) && (32'(dest[2:0]) < nports);
    end
    return r;
  endfunction

endpackage

// File: rtl/pds_fifo.sv
// pds_fifo: synchronous FIFO, registered write, head visible combinationally.
//   clock, reset      - rising-edge clock, synchronous active-high reset
//   push, wdata       - write request and entry
//   pop               - consume head entry (ignored when empty)
//   rdata             - head entry, forced to zero while empty
//   full, empty       - occupancy flags
// A push while full is accepted when a pop happens in the same cycle.
module pds_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pds_if.sv
// pds_if: ingress port of the packet switch.
// Parses byte-serial packets (dest, length, payload), decodes the destination
// into a port mask, checks the length, and queues accepted bytes for the
// fabric tagged with {err, eop, sop, mask}.
//   clock, reset                     - rising-edge clock, sync active-high reset
//   in_valid/in_ready/in_data        - input byte handshake
//   in_sop/in_eop                    - packet delimiters on the input byte
//   out_valid/out_ready/out_data     - output entry handshake
//   out_sop/out_eop/out_mask/out_err - entry tags; out_err valid with out_eop
//   pkt_cnt, err_cnt                 - saturating good / dropped-or-bad counts
module pds_if
  import pds_pkg::*;
#(
  parameter int unsigned PORTNO = 0,
  parameter int unsigned NPORTS = 4,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic [NPORTS-1:0] out_mask,
  output logic              out_err,
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       err_cnt
);

  localparam int unsigned EW = 3 + NPORTS + 8;

  state_t            state;
  state_t            next_state;
  logic [NPORTS-1:0] mask_q;
  logic [7:0]        remain;
  logic [15:0]       pkt_cnt_q;
  logic [15:0]       err_cnt_q;

  dest_dec_t         dec;
  logic [NPORTS-1:0] dec_mask;

  logic              fire;
  logic              want_push;
  logic              w_sop;
  logic              w_eop;
  logic              w_err;
  logic [NPORTS-1:0] w_mask;
  logic              good_pkt;
  logic              bad_pkt;

  logic              fifo_full;
  logic              fifo_empty;
  logic [EW-1:0]     fifo_rdata;

  // PORTNO is informational and the decoded mask is wider than NPORTS.
  logic              unused_bits;
  assign unused_bits = ^{dec.mask, 32'(PORTNO)};

  assign dec      = dest_to_mask(in_data, NPORTS);
  assign dec_mask = dec.mask[NPORTS-1:0];
  assign fire     = in_valid && in_ready;

  // Everything below is what this byte would do if it transfers; the
  // registers and the FIFO only act on it when fire is set.
  always_comb begin
    in_ready   = !fifo_full;
    next_state = state;
    want_push  = 1'b0;
    w_sop      = 1'b0;
    w_eop      = 1'b0;
    w_err      = 1'b0;
    w_mask     = mask_q;
    good_pkt   = 1'b0;
    bad_pkt    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!in_sop) begin
          in_ready = 1'b1;
        end else if (!dec.legal) begin
          in_ready = 1'b1;
          bad_pkt  = 1'b1;
          if (!in_eop) next_state = DROP;
        end else begin
          want_push = 1'b1;
          w_sop     = 1'b1;
          w_mask    = dec_mask;
          // A packet ending on its dest byte still gets closed with an eop.
          if (in_eop) begin
            w_eop   = 1'b1;
            w_err   = 1'b1;
            bad_pkt = 1'b1;
          end else begin
            next_state = LEN;
          end
        end
      end
      LEN: begin
        want_push = 1'b1;
        if (in_data == 8'd0 || in_eop) begin
          w_eop      = 1'b1;
          w_err      = 1'b1;
          bad_pkt    = 1'b1;
          next_state = in_eop ? IDLE : DROP;
        end else begin
          next_state = PAY;
        end
      end
      PAY: begin
        want_push = 1'b1;
        if (in_eop) begin
          w_eop      = 1'b1;
          next_state = IDLE;
          if (remain == 8'd1) begin
            good_pkt = 1'b1;
          end else begin
            w_err   = 1'b1;
            bad_pkt = 1'b1;
          end
        end else if (remain == 8'd1) begin
          w_eop      = 1'b1;
          w_err      = 1'b1;
          bad_pkt    = 1'b1;
          next_state = DROP;
        end
      end
      DROP: begin
        in_ready = 1'b1;
        if (in_eop) next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      mask_q    <= '0;
      remain    <= '0;
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else if (fire) begin
      state <= next_state;
      if (state == IDLE && in_sop && dec.legal) mask_q <= dec_mask;
      if (state == LEN) remain <= in_data;
      if (state == PAY) remain <= remain - 8'd1;
      if (good_pkt && pkt_cnt_q != '1) pkt_cnt_q <= pkt_cnt_q + 16'd1;
      if (bad_pkt && err_cnt_q != '1)  err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  pds_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fire && want_push),
    .wdata ({w_err, w_eop, w_sop, w_mask, in_data}),
    .pop   (out_ready),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign {out_err, out_eop, out_sop, out_mask, out_data} = fifo_rdata;
  assign pkt_cnt   = pkt_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_pds_if.sv
// tb_pds_if: directed test of pds_if (PORTNO=0, NPORTS=4, DEPTH=16).
module tb_pds_if;

  localparam int unsigned NP = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          in_sop;
  logic          in_eop;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic          out_sop;
  logic          out_eop;
  logic [NP-1:0] out_mask;
  logic          out_err;
  logic [15:0]   pkt_cnt;
  logic [15:0]   err_cnt;

  int            total  = 0;
  int            bad    = 0;
  int            stalls = 0;
  logic [14:0]   rxq [$];
  logic [14:0]   expq [$];

  always #5 clock = ~clock;

  pds_if #(
    .PORTNO (0),
    .NPORTS (NP),
    .DEPTH  (16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_mask  (out_mask),
    .out_err   (out_err),
    .pkt_cnt   (pkt_cnt),
    .err_cnt   (err_cnt)
  );

  // Record each output transfer; it completes on the following rising edge.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready)
      rxq.push_back({out_err, out_eop, out_sop, out_mask, out_data});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] ent(input logic err, input logic eop, input logic sop,
                                      input logic [3:0] m, input logic [7:0] d);
    return {err, eop, sop, m, d};
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
    int unsigned waits = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sop   = s;
    in_eop   = e;
    @(negedge clock);
    while (!in_ready && waits < 200) begin
      waits++;
      @(negedge clock);
    end
    if (!in_ready) check("send_timeout", in_ready, 1);
    stalls += int'(waits);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (out_valid && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (out_valid) check("drain_timeout", out_valid, 0);
    repeat (2) @(negedge clock);
    @(posedge clock);
    #1;
  endtask

  task automatic compare_rx(input string tag);
    check({tag, "_count"}, rxq.size(), expq.size());
    for (int i = 0; i < expq.size(); i++)
      check($sformatf("%s_e%0d", tag, i), (i < rxq.size()) ? rxq[i] : 15'h7fff, expq[i]);
    rxq.delete();
    expq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sop    = 1'b0;
    in_eop    = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_out_valid", out_valid, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_fields", {out_err, out_eop, out_sop, out_mask, out_data}, 0);
    @(posedge clock);
    #1;

    // Unicast to port 0, L=3.
    send_byte(8'h00, 1'b1, 1'b0);
    check("t1_latency", out_valid, 1);
    check("t1_head", {out_sop, out_data}, {1'b1, 8'h00});
    send_byte(8'h03, 1'b0, 1'b0);
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'hBB, 1'b0, 1'b0);
    send_byte(8'hCC, 1'b0, 1'b1);
    drain();
    expq = '{ent(0,0,1,4'b0001,8'h00), ent(0,0,0,4'b0001,8'h03), ent(0,0,0,4'b0001,8'hAA),
             ent(0,0,0,4'b0001,8'hBB), ent(0,1,0,4'b0001,8'hCC)};
    compare_rx("t1");
    check("t1_pkt_cnt", pkt_cnt, 1);
    check("t1_err_cnt", err_cnt, 0);

    // Multicast 0x8A -> ports 1 and 3.
    send_byte(8'h8A, 1'b1, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h55, 1'b0, 1'b1);
    drain();
    expq = '{ent(0,0,1,4'b1010,8'h8A), ent(0,0,0,4'b1010,8'h01), ent(0,1,0,4'b1010,8'h55)};
    compare_rx("t2");
    check("t2_pkt_cnt", pkt_cnt, 2);

    // Stray byte in IDLE, then dest port 4 on a 4-port switch.
    stalls = 0;
    send_byte(8'h99, 1'b0, 1'b0);
    send_byte(8'h04, 1'b1, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b1);
    drain();
    check("t3_stalls", stalls, 0);
    compare_rx("t3");
    check("t3_err_cnt", err_cnt, 1);
    check("t3_pkt_cnt", pkt_cnt, 2);

    // Short packet: L=4, only 2 payload bytes.
    send_byte(8'h01, 1'b1, 1'b0);
    send_byte(8'h04, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b1);
    drain();
    expq = '{ent(0,0,1,4'b0010,8'h01), ent(0,0,0,4'b0010,8'h04), ent(0,0,0,4'b0010,8'h11),
             ent(1,1,0,4'b0010,8'h22)};
    compare_rx("t4s");
    check("t4s_err_cnt", err_cnt, 2);

    // Long packet: L=1, three payload bytes.
    send_byte(8'h01, 1'b1, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b1);
    drain();
    expq = '{ent(0,0,1,4'b0010,8'h01), ent(0,0,0,4'b0010,8'h01), ent(1,1,0,4'b0010,8'h11)};
    compare_rx("t4l");
    check("t4l_err_cnt", err_cnt, 3);
    check("t4l_pkt_cnt", pkt_cnt, 2);

    // Backpressure: 20-byte packet to port 2 with the fabric stalled.
    out_ready = 1'b0;
    send_byte(8'h02, 1'b1, 1'b0);
    send_byte(8'h12, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) send_byte(8'(8'h30 + i), 1'b0, 1'b0);
    check("t5_full_ready", in_ready, 0);
    check("t5_hold_a", {out_valid, out_sop, out_mask, out_data}, {1'b1, 1'b1, 4'b0100, 8'h02});
    repeat (3) @(posedge clock);
    #1;
    check("t5_hold_b", {out_valid, out_sop, out_mask, out_data}, {1'b1, 1'b1, 4'b0100, 8'h02});
    check("t5_still_full", in_ready, 0);
    out_ready = 1'b1;
    for (int i = 14; i < 18; i++) send_byte(8'(8'h30 + i), 1'b0, i == 17);
    drain();
    expq.push_back(ent(0,0,1,4'b0100,8'h02));
    expq.push_back(ent(0,0,0,4'b0100,8'h12));
    for (int i = 0; i < 18; i++) expq.push_back(ent(0, i == 17, 0, 4'b0100, 8'(8'h30 + i)));
    compare_rx("t5");
    check("t5_pkt_cnt", pkt_cnt, 3);

    // Reset in the middle of a payload with entries queued.
    out_ready = 1'b0;
    send_byte(8'h01, 1'b1, 1'b0);
    send_byte(8'h05, 1'b0, 1'b0);
    send_byte(8'hA1, 1'b0, 1'b0);
    send_byte(8'hA2, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("t6_out_valid", out_valid, 0);
    check("t6_pkt_cnt", pkt_cnt, 0);
    check("t6_err_cnt", err_cnt, 0);
    check("t6_out_fields", {out_err, out_eop, out_sop, out_mask, out_data}, 0);
    rxq.delete();
    out_ready = 1'b1;
    send_byte(8'h03, 1'b1, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h77, 1'b0, 1'b1);
    drain();
    expq = '{ent(0,0,1,4'b1000,8'h03), ent(0,0,0,4'b1000,8'h01), ent(0,1,0,4'b1000,8'h77)};
    compare_rx("t6");
    check("t6_pkt_cnt_after", pkt_cnt, 1);
    check("t6_err_cnt_after", err_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
